apb_slave_adapter: RTL
======================

Name: apb_slave_adapter

Overview:
Parametrised APB4 slave front-end that converts APB transfers into the slave-adapter request/acknowledge protocol used by interface_control_logic. It succeeds the fixed 32-bit, 12-bit-address APB glue inside lw_sha_apb_top. New capabilities:
- generic data and address width;
- PSTRB byte enables;
- address range and alignment checking;
- a wait-state timeout that converts a hung back end into PSLVERR and a stuck flag.

Parameters:
- D_WIDTH, 32: APB and back-end data width; must be 32 or 64.
- A_WIDTH, 12: paddr width.
- STRB_EN, 1: 1 forwards pstrb; 0 forces all byte enables to ones.
- ADDR_MAX, 12'hFFF: highest legal byte address; anything above it is an error.
- TIMEOUT, 255: maximum back-end wait cycles before forced completion; 0 disables the timeout.

Ports:
- pclk, in, 1: clock.
- presetn, in, 1: asynchronous active-low reset.
- paddr, in, A_WIDTH: APB address.
- psel, in, 1: select.
- penable, in, 1: access phase.
- pwrite, in, 1: 1 = write.
- pwdata, in, D_WIDTH: write data.
- pstrb, in, D_WIDTH/8: write byte strobes.
- pready, out, 1: transfer complete.
- prdata, out, D_WIDTH: read data.
- pslverr, out, 1: transfer error.
- wr_o, out, 1: write request to back end.
- wr_ack_i, in, 1: write accepted.
- waddr_o, out, A_WIDTH: write address.
- wdata_o, out, D_WIDTH: write data.
- wbyte_enable_o, out, D_WIDTH/8: write byte enables.
- rd_o, out, 1: read request pulse.
- raddr_o, out, A_WIDTH: read address.
- rbyte_enable_o, out, D_WIDTH/8: read byte enables, always all ones.
- rdata_i, in, D_WIDTH: read data from back end.
- read_valid_i, in, 1: rdata_i valid.
- read_ready_o, out, 1: adapter ready to take read data.
- wstuck_o, out, 1: one-cycle pulse on write timeout.
- rstuck_o, out, 1: one-cycle pulse on read timeout.

Behaviour:
- Clocking and reset: single clock pclk; reset presetn is asynchronous and active-low.
- Reset values: all outputs are 0, except rbyte_enable_o, which is all ones. The FSM resets to IDLE and the timeout counter to 0.
- FSM states: IDLE, WREQ, RREQ, RWAIT, RESP.
- IDLE, on the setup phase (psel=1, penable=0):
  - Register paddr, pwdata and the strobes (all ones if STRB_EN=0).
  - Error check: paddr > ADDR_MAX, or paddr[clog2(D_WIDTH/8)-1:0] != 0. On error, latch err=1 and go to RESP with no back-end request.
  - Write with zero strobes: go to RESP, no error, no wr_o.
  - Otherwise go to WREQ (pwrite=1) or RREQ (pwrite=0).
- WREQ:
  - wr_o=1, with waddr_o, wdata_o and wbyte_enable_o held stable.
  - When wr_ack_i=1 in the same cycle, go to RESP.
- RREQ:
  - rd_o=1 for exactly one cycle, then go to RWAIT.
- RWAIT:
  - read_ready_o=1.
  - When read_valid_i=1, capture rdata_i into prdata and go to RESP.
- RESP:
  - pready=1 and pslverr=err for exactly one cycle, then go to IDLE.
  - prdata is valid in this cycle for reads and is 0 for errors and writes.
- Minimum latency, setup at cycle T:
  - Write with wr_ack_i already high: pready at T+2 (one wait state).
  - Read with read_valid_i high in RWAIT: pready at T+3.
- Timeout:
  - The counter increments each cycle spent in WREQ or RWAIT and clears on entry to RESP.
  - When it reaches TIMEOUT (TIMEOUT != 0), go to RESP with err=1, pulse wstuck_o or rstuck_o, and drop wr_o / read_ready_o in the same cycle.
  - A late wr_ack_i or read_valid_i after a timeout is ignored.
- Ack and timeout in the same cycle: the acknowledge wins; no error, no stuck pulse.
- psel deasserted while not in IDLE (protocol violation): abort to IDLE on the next cycle. Drop all requests, do not assert pready, clear err.
- presetn low mid-transfer: everything returns to reset values immediately, and no partial request persists.
- pready is 0 outside RESP; the adapter never completes in a zero-wait-state cycle.

Decomposition:
- Package apb_adapter_pkg:
  - state enum apb_st_e {IDLE, WREQ, RREQ, RWAIT, RESP};
  - localparam function byte_off_w(D_WIDTH) = clog2(D_WIDTH/8);
  - TIMEOUT counter width localparam = clog2(TIMEOUT+1).
- One sub-module, apb_wait_timer: counter with enable, clear and expire outputs, reused later by the AXI adapter.

Test Plan:
- Write, D_WIDTH=32: paddr=0x010, pwdata=0xA5A5_0001, pstrb=4'b0011, wr_ack_i high on the first WREQ cycle. Required: wr_o for 1 cycle with wbyte_enable_o=0011 and waddr_o=0x010; pready 2 cycles after setup; pslverr=0.
- Read with read_valid_i 3 cycles after rd_o, rdata_i=0xDEAD_BEEF. Required: rd_o exactly one cycle; prdata=0xDEADBEEF with pready; pslverr=0.
- paddr=0x013 (misaligned), then paddr above ADDR_MAX=0x0FF. Required: pready+pslverr=1 at T+1 after setup; no wr_o or rd_o.
- TIMEOUT=4, wr_ack_i held low. Required: wstuck_o pulse and pready+pslverr after 4 WREQ cycles; wr_o low afterwards. A later wr_ack_i causes no new activity.
- STRB_EN=0, pstrb=0; then STRB_EN=1, pstrb=0. Required: first case wbyte_enable_o=4'hF; second case pready with no wr_o and no error.
- Reset and abort: assert presetn low in RWAIT, or drop psel in WREQ. Required: outputs return to reset values, FSM to IDLE; the next transfer completes normally.

Source files
------------

// File: rtl/apb_adapter_pkg.sv
// Shared types and width helpers for the APB slave adapter and its wait timer.
package apb_adapter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        RREQ,
        RWAIT,
        RESP
    } apb_st_e;

    function automatic int unsigned byte_off_w(input int unsigned d_width);
        return $clog2(d_width / 8);
    endfunction

    // A disabled timer (timeout 0) still needs a legal 1-bit counter.
    function automatic int unsigned timer_w(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter: counts enabled cycles, expires on the TIMEOUT-th one.
module apb_wait_timer
    import apb_adapter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam int unsigned CNT_W = timer_w(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire_c = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/apb_slave_adapter.sv
// APB4 slave front-end translating transfers into the back-end req/ack protocol,
// with range/alignment checks and a wait-state timeout.
module apb_slave_adapter
    import apb_adapter_pkg::*;
#(
    parameter int unsigned          D_WIDTH  = 32,
    parameter int unsigned          A_WIDTH  = 12,
    parameter bit                   STRB_EN  = 1'b1,
    parameter logic [A_WIDTH-1:0]   ADDR_MAX = A_WIDTH'(12'hFFF),
    parameter int unsigned          TIMEOUT  = 255
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic [A_WIDTH-1:0]     paddr,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [D_WIDTH-1:0]     pwdata,
    input  logic [D_WIDTH/8-1:0]   pstrb,
    output logic                   pready,
    output logic [D_WIDTH-1:0]     prdata,
    output logic                   pslverr,
    output logic                   wr_o,
    input  logic                   wr_ack_i,
    output logic [A_WIDTH-1:0]     waddr_o,
    output logic [D_WIDTH-1:0]     wdata_o,
    output logic [D_WIDTH/8-1:0]   wbyte_enable_o,
    output logic                   rd_o,
    output logic [A_WIDTH-1:0]     raddr_o,
    output logic [D_WIDTH/8-1:0]   rbyte_enable_o,
    input  logic [D_WIDTH-1:0]     rdata_i,
    input  logic                   read_valid_i,
    output logic                   read_ready_o,
    output logic                   wstuck_o,
    output logic                   rstuck_o
);

    localparam int unsigned STRB_W = D_WIDTH / 8;
    localparam int unsigned BOFF_W = byte_off_w(D_WIDTH);

    apb_st_e              state_q, state_d;
    logic                 err_q, err_d;
    logic [A_WIDTH-1:0]   addr_q, addr_d;
    logic [D_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]    strb_q, strb_d;
    logic [D_WIDTH-1:0]   prdata_d;
    logic                 wstuck_d, rstuck_d;
    logic [STRB_W-1:0]    strb_sel;
    logic                 addr_err;
    logic                 timer_en, timer_clr, expire_c;

    assign strb_sel  = STRB_EN ? pstrb : '1;
    assign addr_err  = (paddr > ADDR_MAX) || (paddr[BOFF_W-1:0] != '0);
    assign timer_en  = (state_q == WREQ) || (state_q == RWAIT);
    assign timer_clr = (state_d != WREQ) && (state_d != RWAIT);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (pclk),
        .rst_n    (presetn),
        .en       (timer_en),
        .clr      (timer_clr),
        .expire_c (expire_c)
    );

    // Next-state and next-output decode; a dropped psel always wins and aborts.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        prdata_d = '0;
        wstuck_d = 1'b0;
        rstuck_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    strb_d  = strb_sel;
                    err_d   = addr_err;
                    if (addr_err || (pwrite && (strb_sel == '0))) begin
                        state_d = RESP;
                    end else begin
                        state_d = pwrite ? WREQ : RREQ;
                    end
                end
            end
            WREQ: begin
                if (!psel) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end else if (wr_ack_i) begin
                    state_d = RESP;
                end else if (expire_c) begin
                    state_d  = RESP;
                    err_d    = 1'b1;
                    wstuck_d = 1'b1;
                end
            end
            RREQ: begin
                if (!psel) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end else begin
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end else if (read_valid_i) begin
                    state_d  = RESP;
                    prdata_d = rdata_i;
                end else if (expire_c) begin
                    state_d  = RESP;
                    err_d    = 1'b1;
                    rstuck_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // State, request payload and registered APB/back-end outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            pready       <= 1'b0;
            pslverr      <= 1'b0;
            prdata       <= '0;
            wr_o         <= 1'b0;
            rd_o         <= 1'b0;
            read_ready_o <= 1'b0;
            wstuck_o     <= 1'b0;
            rstuck_o     <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            pready       <= (state_d == RESP);
            pslverr      <= (state_d == RESP) && err_d;
            prdata       <= prdata_d;
            wr_o         <= (state_d == WREQ);
            rd_o         <= (state_d == RREQ);
            read_ready_o <= (state_d == RWAIT);
            wstuck_o     <= wstuck_d;
            rstuck_o     <= rstuck_d;
        end
    end

    assign waddr_o        = addr_q;
    assign raddr_o        = addr_q;
    assign wdata_o        = wdata_q;
    assign wbyte_enable_o = strb_q;
    assign rbyte_enable_o = '1;

endmodule
